// File: rtl/ts_byte_packer.sv
// ts_byte_packer
// Locks onto a byte-wide packetised stream and packs bytes MSB-first into
// DATA_WIDTH-bit words for the capture-path word FIFO. Everything runs on wclk.
//
// Ports:
//   wclk        clock, rising edge
//   rst_n       synchronous active-low reset
//   din         input byte
//   din_valid   din carries a byte this cycle
//   din_sop     first byte of a packet (qualified by din_valid)
//   dout        packed word, holds between strobes
//   dout_valid  one-cycle strobe, dout is a new word
//   dout_sop    with dout_valid: word holds a packet's first byte
//   error_sync  one-cycle pulse on a sync violation
//   pkt_count   packets fully emitted since reset (wraps)
module ts_byte_packer #(
  parameter int         DATA_WIDTH   = 32,
  parameter int         PACKET_BYTES = 188,
  parameter logic [7:0] PAD_BYTE     = 8'hFF
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic [7:0]            din,
  input  logic                  din_valid,
  input  logic                  din_sop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  dout_sop,
  output logic                  error_sync,
  output logic [31:0]           pkt_count
);

  localparam int BPW    = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BPW);
  localparam int IDX_W  = $clog2(PACKET_BYTES);

  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(BPW - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(PACKET_BYTES - 1);
  localparam logic [DATA_WIDTH-1:0] PAD_WORD  = {BPW{PAD_BYTE}};

  typedef enum logic {HUNT, PACK} state_t;

  state_t                state;
  logic [IDX_W-1:0]      byte_idx;
  logic [LANE_W-1:0]     lane;
  logic [DATA_WIDTH-1:0] word_buf;
  logic                  word_sop;

  logic                  store;
  logic                  start;
  logic                  sync_err;
  logic                  lost_sync;
  logic [IDX_W-1:0]      eff_idx;
  logic [LANE_W-1:0]     eff_lane;
  logic [DATA_WIDTH-1:0] new_word;
  logic                  new_sop;
  logic                  word_done;
  logic                  pkt_done;

  // A sop byte always (re)starts a packet at byte 0; a non-sop byte is only
  // kept when we are locked and mid-packet. A fresh word starts from the pad
  // pattern so a truncated final word already has PAD_BYTE in its unused lanes.
  always_comb begin
    start     = din_valid && din_sop;
    store     = din_valid && (din_sop || (state == PACK && byte_idx != '0));
    sync_err  = din_valid && (state == PACK) &&
                ((din_sop && byte_idx != '0) || (!din_sop && byte_idx == '0));
    lost_sync = din_valid && (state == PACK) && !din_sop && (byte_idx == '0);

    eff_idx  = start ? '0 : byte_idx;
    eff_lane = start ? '0 : lane;

    new_word = (eff_lane == '0) ? PAD_WORD : word_buf;
    for (int l = 0; l < BPW; l++) begin
      if (eff_lane == LANE_W'(l)) begin
        new_word[DATA_WIDTH-1-8*l -: 8] = din;
      end
    end

    new_sop   = (eff_lane == '0) ? (eff_idx == '0) : word_sop;
    pkt_done  = (eff_idx == LAST_IDX);
    word_done = (eff_lane == LAST_LANE) || pkt_done;
  end

  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      state      <= HUNT;
      byte_idx   <= '0;
      lane       <= '0;
      word_buf   <= '0;
      word_sop   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      error_sync <= 1'b0;
      pkt_count  <= '0;
    end else begin
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      error_sync <= sync_err;

      if (lost_sync) begin
        state <= HUNT;
      end else if (store) begin
        state    <= PACK;
        word_buf <= new_word;
        word_sop <= new_sop;

        if (word_done) begin
          dout       <= new_word;
          dout_valid <= 1'b1;
          dout_sop   <= new_sop;
        end

        if (pkt_done) begin
          byte_idx  <= '0;
          lane      <= '0;
          pkt_count <= pkt_count + 32'd1;
        end else begin
          byte_idx <= eff_idx + 1'b1;
          lane     <= word_done ? '0 : eff_lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ts_byte_packer.sv
// tb_ts_byte_packer
// Drives one byte stream into a 32-bit and a 64-bit ts_byte_packer (188-byte
// packets). Expected words and error pulses, each tagged with the cycle they
// must appear on, are queued as bytes are issued; per-instance monitors pop
// and compare whenever the DUT strobes.
module tb_ts_byte_packer;

  logic        wclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_sop = 1'b0;

  logic [31:0] dout32;
  logic        dout_valid32, dout_sop32, err32;
  logic [31:0] pkt32;
  logic [63:0] dout64;
  logic        dout_valid64, dout_sop64, err64;
  logic [31:0] pkt64;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic [31:0] pkt;
    longint      cyc;
  } exp_word_t;

  exp_word_t q32[$];
  exp_word_t q64[$];
  longint    eq32[$];
  longint    eq64[$];

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     exp_pkt = 0;
  int     n32 = 0;
  int     n64 = 0;

  ts_byte_packer #(.DATA_WIDTH(32), .PACKET_BYTES(188), .PAD_BYTE(8'hFF)) dut32 (
    .wclk(wclk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_sop(din_sop),
    .dout(dout32), .dout_valid(dout_valid32), .dout_sop(dout_sop32),
    .error_sync(err32), .pkt_count(pkt32)
  );

  ts_byte_packer #(.DATA_WIDTH(64), .PACKET_BYTES(188), .PAD_BYTE(8'hFF)) dut64 (
    .wclk(wclk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_sop(din_sop),
    .dout(dout64), .dout_valid(dout_valid64), .dout_sop(dout_sop64),
    .error_sync(err64), .pkt_count(pkt64)
  );

  always #5 wclk = ~wclk;

  always @(posedge wclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Packet byte i carries value i; the word ending at last_idx holds the
  // bytes of its group, with 0xFF beyond byte 187.
  function automatic logic [63:0] exp_word(input int nb, input int last_idx);
    logic [63:0] w;
    int          idx;
    logic [7:0]  b;
    w = '0;
    for (int k = 0; k < nb; k++) begin
      idx = last_idx - (last_idx % nb) + k;
      b   = (idx < 188) ? idx[7:0] : 8'hFF;
      w   = {w[55:0], b};
    end
    return w;
  endfunction

  task automatic applyStimulus(input logic [7:0] b, input logic sop, input logic valid);
    @(negedge wclk);
    din       = b;
    din_sop   = sop;
    din_valid = valid;
  endtask

  task automatic send_byte(input int idx, input logic sop);
    exp_word_t e;
    applyStimulus(idx[7:0], sop, 1'b1);
    if (idx == 187) exp_pkt++;
    if ((idx % 4 == 3) || idx == 187) begin
      e.data = exp_word(4, idx);
      e.sop  = (idx < 4);
      e.pkt  = exp_pkt;
      e.cyc  = cyc + 1;
      q32.push_back(e);
    end
    if ((idx % 8 == 7) || idx == 187) begin
      e.data = exp_word(8, idx);
      e.sop  = (idx < 8);
      e.pkt  = exp_pkt;
      e.cyc  = cyc + 1;
      q64.push_back(e);
    end
  endtask

  task automatic push_err();
    eq32.push_back(cyc + 1);
    eq64.push_back(cyc + 1);
  endtask

  // Gaps drive din_sop high with din_valid low, which must be ignored.
  task automatic send_packet(input int n, input bit gappy, input bit sop_err);
    for (int i = 0; i < n; i++) begin
      if (gappy && i > 0) begin
        repeat ($urandom_range(0, 2)) applyStimulus(8'hEE, 1'b1, 1'b0);
      end
      send_byte(i, i == 0);
      if (i == 0 && sop_err) push_err();
    end
  endtask

  task automatic drain(input string tag);
    repeat (4) applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput({tag, "_q32_left"}, q32.size(), 0);
    checkOutput({tag, "_q64_left"}, q64.size(), 0);
    checkOutput({tag, "_err32_left"}, eq32.size(), 0);
    checkOutput({tag, "_err64_left"}, eq64.size(), 0);
    q32.delete();
    q64.delete();
    eq32.delete();
    eq64.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge wclk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din_sop   = 1'b0;
    din       = 8'h00;
    @(negedge wclk);
    rst_n   = 1'b1;
    exp_pkt = 0;
    checkOutput({tag, "_rst_dout32"}, dout32, 0);
    checkOutput({tag, "_rst_dout64"}, dout64, 0);
    checkOutput({tag, "_rst_valid"}, {dout_valid32, dout_valid64}, 0);
    checkOutput({tag, "_rst_sop"}, {dout_sop32, dout_sop64}, 0);
    checkOutput({tag, "_rst_err"}, {err32, err64}, 0);
    checkOutput({tag, "_rst_pkt32"}, pkt32, 0);
    checkOutput({tag, "_rst_pkt64"}, pkt64, 0);
    n32 = 0;
    n64 = 0;
  endtask

  // Monitors: sample half a cycle after the active edge.
  always @(negedge wclk) begin
    exp_word_t e;
    longint    ec;
    if (dout_valid32) begin
      n32++;
      if (q32.size() == 0) checkOutput("w32_unexpected_strobe", 1, 0);
      else begin
        e = q32.pop_front();
        checkOutput("w32_data", {32'b0, dout32}, e.data);
        checkOutput("w32_sop", dout_sop32, e.sop);
        checkOutput("w32_pkt_count", pkt32, e.pkt);
        checkOutput("w32_strobe_cycle", cyc, e.cyc);
      end
    end
    if (err32) begin
      if (eq32.size() == 0) checkOutput("e32_unexpected_error", 1, 0);
      else begin
        ec = eq32.pop_front();
        checkOutput("e32_error_cycle", cyc, ec);
      end
    end
  end

  always @(negedge wclk) begin
    exp_word_t e;
    longint    ec;
    if (dout_valid64) begin
      n64++;
      if (q64.size() == 0) checkOutput("w64_unexpected_strobe", 1, 0);
      else begin
        e = q64.pop_front();
        checkOutput("w64_data", dout64, e.data);
        checkOutput("w64_sop", dout_sop64, e.sop);
        checkOutput("w64_pkt_count", pkt64, e.pkt);
        checkOutput("w64_strobe_cycle", cyc, e.cyc);
      end
    end
    if (err64) begin
      if (eq64.size() == 0) checkOutput("e64_unexpected_error", 1, 0);
      else begin
        ec = eq64.pop_front();
        checkOutput("e64_error_cycle", cyc, ec);
      end
    end
  end

  initial begin
    // Aligned packet (32-bit) and padded final word (64-bit).
    do_reset("s1");
    send_packet(188, 1'b0, 1'b0);
    drain("s1");
    checkOutput("s1_strobes32", n32, 47);
    checkOutput("s1_strobes64", n64, 24);
    checkOutput("s1_last32", dout32, 32'hB8B9BABB);
    checkOutput("s1_last64", dout64, 64'hB8B9BABBFFFFFFFF);
    checkOutput("s1_pkt32", pkt32, 1);
    checkOutput("s1_pkt64", pkt64, 1);

    // Random input gaps.
    do_reset("s2");
    send_packet(188, 1'b1, 1'b0);
    drain("s2");
    checkOutput("s2_strobes32", n32, 47);
    checkOutput("s2_strobes64", n64, 24);
    checkOutput("s2_pkt32", pkt32, 1);

    // sop arriving at byte_idx 10, then a full packet.
    do_reset("s3");
    send_packet(10, 1'b0, 1'b0);
    send_packet(188, 1'b0, 1'b1);
    drain("s3");
    checkOutput("s3_strobes32", n32, 49);
    checkOutput("s3_strobes64", n64, 25);
    checkOutput("s3_pkt32", pkt32, 1);
    checkOutput("s3_pkt64", pkt64, 1);

    // Lost sync after a complete packet, then recovery.
    do_reset("s4");
    send_packet(188, 1'b0, 1'b0);
    applyStimulus(8'h55, 1'b0, 1'b1);
    push_err();
    applyStimulus(8'h56, 1'b0, 1'b1);
    applyStimulus(8'h57, 1'b0, 1'b1);
    drain("s4a");
    send_packet(188, 1'b0, 1'b0);
    drain("s4b");
    checkOutput("s4_strobes32", n32, 94);
    checkOutput("s4_pkt32", pkt32, 2);
    checkOutput("s4_pkt64", pkt64, 2);

    // Reset at byte_idx 50, stray non-sop bytes, then a clean packet.
    do_reset("s5");
    send_packet(50, 1'b0, 1'b0);
    checkOutput("s5_pre_pkt32", pkt32, 0);
    do_reset("s5mid");
    applyStimulus(8'h33, 1'b0, 1'b1);
    applyStimulus(8'h34, 1'b0, 1'b1);
    applyStimulus(8'h35, 1'b0, 1'b1);
    drain("s5a");
    checkOutput("s5_stray_strobes", n32 + n64, 0);
    send_packet(188, 1'b0, 1'b0);
    drain("s5b");
    checkOutput("s5_strobes32", n32, 47);
    checkOutput("s5_pkt32", pkt32, 1);
    checkOutput("s5_pkt64", pkt64, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ts_byte_packer.md
# ts_byte_packer

Upstream feeder for the word FIFO in the capture path. Accepts a byte-wide packetised stream on wclk, locks to packet starts, and packs bytes MSB-first into DATA_WIDTH words. Presents one word per completed group on dout with a one-cycle dout_valid strobe, plus packet-start marking and sync-error reporting. Runs entirely in the wclk domain; the FIFO consumes dout/dout_valid on the same clock.

## Interface
- DATA_WIDTH, 32, output word width; multiple of 8, 16..64.
- PACKET_BYTES, 188, bytes per packet; >= 2.
- PAD_BYTE, 8'hFF, filler for the unused low bytes of a packet's final partial word.
- wclk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low; sampled on wclk.
- din  in  8  input byte.
- din_valid  in  1  din carries a byte this cycle.
- din_sop  in  1  qualified by din_valid; byte is the first of a packet.
- dout  out  DATA_WIDTH  packed word; holds its last value between strobes.
- dout_valid  out  1  one-cycle strobe; dout is a new word.
- dout_sop  out  1  valid with dout_valid; word holds a packet's first byte.
- error_sync  out  1  one-cycle pulse on a sync violation.
- pkt_count  out  32  packets fully emitted since reset; wraps at 2^32.

## Operation
- States: HUNT, PACK.
- HUNT: all bytes discarded. A byte with din_valid=1 and din_sop=1 moves to PACK and is stored as byte 0 of a new packet.
- PACK: each byte with din_valid=1 is stored at lane (byte_idx mod BPW), where BPW = DATA_WIDTH/8. Lane 0 is dout[DATA_WIDTH-1 -: 8] (MSB-first). byte_idx counts 0..PACKET_BYTES-1.
- Word completion:
  - When lane BPW-1 is filled, the word is emitted.
  - When byte_idx = PACKET_BYTES-1 is filled, the word is emitted with the unfilled lanes set to PAD_BYTE. The packet is then complete: pkt_count increments, byte_idx returns to 0, and the state stays PACK, expecting a sop.
- dout_sop=1 for the emitted word that contains byte_idx 0.
- Sync violations (either one pulses error_sync for one cycle):
  - In PACK, din_sop=1 with byte_idx != 0: discard the partial word and the rest of the packet, with no emit and no pkt_count change. Treat this byte as byte 0 of a new packet and stay in PACK.
  - In PACK, byte_idx = 0 and din_valid=1 but din_sop=0: discard the byte and go to HUNT.
- din_valid=0 cycles: no state change, no emit. Gaps anywhere in a packet are legal.
- din_sop is ignored when din_valid=0.

## Timing
- Reset values:
  - Outputs: dout=0, dout_valid=0, dout_sop=0, error_sync=0, pkt_count=0.
  - Internal: state=HUNT, byte_idx=0, partial lanes cleared.
- Reset mid-packet drops all partial data. The first cycle with rst_n=1 is in HUNT.
- Latency:
  - The byte that completes a word at edge N produces dout_valid=1 on the cycle after edge N, i.e. a 1-cycle registered output.
  - error_sync is asserted on the cycle after the offending byte.
  - pkt_count updates in the same cycle as the final word's dout_valid.
- At most one word per cycle; no backpressure. At full input rate, dout_valid duty is 1/BPW.
- The byte following a completed word or packet may arrive on the very next edge. It is stored into lane 0 of a fresh word with no bubble.

## Test plan
- Aligned packet, DATA_WIDTH=32, PACKET_BYTES=188, continuous bytes 0x00..0xBB starting with sop:
  - 47 strobes; first dout=0x00010203 with dout_sop=1; last dout=0xB8B9BABB.
  - pkt_count=1; error_sync never asserted.
- Unaligned pad, DATA_WIDTH=64, PACKET_BYTES=188, same bytes:
  - 24 strobes; last dout=0xB8B9BABBFFFFFFFF.
  - Each strobe 1 cycle after its 8th lane byte.
- Gappy input: same 32-bit packet with din_valid toggling 1,0,0,1,... (random gaps):
  - Word values identical to scenario 1; strobes only after lane-3 bytes.
- Mid-packet sop: sop at byte_idx 10, followed by a full 188-byte packet:
  - error_sync pulse 1 cycle later; no emit of bytes 8..9.
  - Next packet's first word has dout_sop=1; pkt_count=1 at end.
- Lost sync: after a complete packet, bytes with din_sop=0:
  - error_sync once; state HUNT; no strobes until the next sop.
  - Recovery packet emits normally.
- Reset mid-packet: rst_n=0 for 1 cycle at byte_idx 50:
  - All outputs 0 next cycle; non-sop bytes are ignored.
  - New sop packet emits 47 words; pkt_count=1.
